// File: rtl/wr_port_pkg.sv
// ---------------------------------------------------------------------------
// wr_port_pkg
// Shared default constants for the register-file write-port buffer.
//   WR_PORT_NUM_PORTS : number of write source ports feeding the buffer
//   WR_PORT_ADDR_W    : register-file write address width
//   WR_PORT_DATA_W    : register-file write data width
//   WR_PORT_BUF_DEPTH : entries held between the source mux and the RF port
// ---------------------------------------------------------------------------
package wr_port_pkg;

  localparam int WR_PORT_NUM_PORTS = 8;
  localparam int WR_PORT_ADDR_W    = 6;
  localparam int WR_PORT_DATA_W    = 64;
  localparam int WR_PORT_BUF_DEPTH = 2;

endpackage : wr_port_pkg

// File: rtl/wr_port_skid_fifo.sv
// ---------------------------------------------------------------------------
// wr_port_skid_fifo
// Two-entry valid/ready FIFO that holds every bit of buffered write state.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   in_valid/in_ready      : push handshake; in_ready depends on occupancy only
//   in_addr/in_data        : entry pushed on in_valid & in_ready
//   out_valid/out_ready    : pop handshake toward the register file
//   out_addr/out_data      : head entry, forced to zero when empty
//   entry_valid/entry_addr : per-slot view used for the read-hazard compare
// ---------------------------------------------------------------------------
module wr_port_skid_fifo
  import wr_port_pkg::*;
#(
  parameter int ADDR_W = WR_PORT_ADDR_W,
  parameter int DATA_W = WR_PORT_DATA_W
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [ADDR_W-1:0]                        in_addr,
  input  logic [DATA_W-1:0]                        in_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [ADDR_W-1:0]                        out_addr,
  output logic [DATA_W-1:0]                        out_data,
  output logic [WR_PORT_BUF_DEPTH-1:0]             entry_valid,
  output logic [WR_PORT_BUF_DEPTH-1:0][ADDR_W-1:0] entry_addr
);

  logic [ADDR_W-1:0] addr_q [WR_PORT_BUF_DEPTH];
  logic [DATA_W-1:0] data_q [WR_PORT_BUF_DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              push;
  logic              pop;

  assign in_ready  = (count < 2'(WR_PORT_BUF_DEPTH));
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Empty buffer drives zeros so stale slot contents never reach the RF.
  assign out_addr = out_valid ? addr_q[rd_ptr] : '0;
  assign out_data = out_valid ? data_q[rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: slot storage has no reset; validity comes solely from count, so
  // a reset only needs to clear the pointers and the occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= in_addr;
      data_q[wr_ptr] <= in_data;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    entry_valid = '0;
    if (count != 2'd0) entry_valid[rd_ptr]  = 1'b1;
    if (count == 2'd2) entry_valid[~rd_ptr] = 1'b1;
    for (int i = 0; i < WR_PORT_BUF_DEPTH; i++) entry_addr[i] = addr_q[i];
  end

endmodule : wr_port_skid_fifo

// File: rtl/wr_port_nx_buf.sv
// ---------------------------------------------------------------------------
// wr_port_nx_buf
// Selects one of NUM_PORTS write sources, buffers the write in a two-entry
// FIFO and presents it to a register-file write port, with an address
// hazard query against all buffered writes.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   select                       : one-hot source select from issue
//   port_wr_en/addr/data         : per-port write request, port i at slice i
//   in_ready                     : buffer can take a write this cycle
//   muxed_port_wr_en/addr/data   : head entry toward the register file
//   muxed_port_wr_ready          : register file consumes the head entry
//   chk_addr/chk_hit             : combinational pending-write hazard lookup
//   err_clr/err_multi_sel/err_sel: multi-hot select error status
// Build option WR_PORT_MULTI_SEL_CHK_EN: multi-hot selects are dropped and
// flagged; without it the lowest-index selected port wins and the error
// outputs are tied low.
// ---------------------------------------------------------------------------
module wr_port_nx_buf
  import wr_port_pkg::*;
#(
  parameter int NUM_PORTS = WR_PORT_NUM_PORTS,
  parameter int ADDR_W    = WR_PORT_ADDR_W,
  parameter int DATA_W    = WR_PORT_DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          select,
  input  logic [NUM_PORTS-1:0]          port_wr_en,
  input  logic [NUM_PORTS*ADDR_W-1:0]   port_wr_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   port_wr_data,
  output logic                          in_ready,
  output logic                          muxed_port_wr_en,
  output logic [ADDR_W-1:0]             muxed_port_wr_addr,
  output logic [DATA_W-1:0]             muxed_port_wr_data,
  input  logic                          muxed_port_wr_ready,
  input  logic [ADDR_W-1:0]             chk_addr,
  output logic                          chk_hit,
  input  logic                          err_clr,
  output logic                          err_multi_sel,
  output logic [NUM_PORTS-1:0]          err_sel
);

  logic [NUM_PORTS-1:0]                    eff_sel;
  logic                                    sel_en;
  logic [ADDR_W-1:0]                       sel_addr;
  logic [DATA_W-1:0]                       sel_data;
  logic [WR_PORT_BUF_DEPTH-1:0]             entry_valid;
  logic [WR_PORT_BUF_DEPTH-1:0][ADDR_W-1:0] entry_addr;

`ifdef WR_PORT_MULTI_SEL_CHK_EN
  logic is_multi;

  // x & (x-1) clears the lowest set bit; anything left means 2+ bits set.
  assign is_multi = ((select & (select - NUM_PORTS'(1))) != '0);
  assign eff_sel  = is_multi ? '0 : select;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_multi_sel <= 1'b0;
      err_sel       <= '0;
    end else if (err_clr) begin
      // A clear coinciding with a new violation re-arms with the new capture.
      err_multi_sel <= is_multi;
      err_sel       <= is_multi ? select : '0;
    end else if (is_multi && !err_multi_sel) begin
      err_multi_sel <= 1'b1;
      err_sel       <= select;
    end
  end
`else
  logic unused_err_clr;

  // x & -x isolates the lowest set bit: fixed priority toward port 0.
  assign eff_sel        = select & (~select + NUM_PORTS'(1));
  assign err_multi_sel  = 1'b0;
  assign err_sel        = '0;
  assign unused_err_clr = err_clr;
`endif

  // eff_sel is one-hot or zero, so an OR-reduction is the mux.
  always_comb begin
    sel_en   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (eff_sel[i]) begin
        sel_en   = sel_en   | port_wr_en[i];
        sel_addr = sel_addr | port_wr_addr[i*ADDR_W +: ADDR_W];
        sel_data = sel_data | port_wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  wr_port_skid_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (sel_en),
    .in_ready    (in_ready),
    .in_addr     (sel_addr),
    .in_data     (sel_data),
    .out_valid   (muxed_port_wr_en),
    .out_ready   (muxed_port_wr_ready),
    .out_addr    (muxed_port_wr_addr),
    .out_data    (muxed_port_wr_data),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr)
  );

  always_comb begin
    chk_hit = 1'b0;
    for (int i = 0; i < WR_PORT_BUF_DEPTH; i++) begin
      if (entry_valid[i] && (entry_addr[i] == chk_addr)) chk_hit = 1'b1;
    end
  end

endmodule : wr_port_nx_buf
